dm_arbiter: RTL
===============

# dm_arbiter

Two-port arbiter and sequencer in front of the single data-memory port. It shares that port between requester 0 (CPU M stage, already carrying byte-enables and aligned store data) and requester 1 (bridge/DMA device path). It runs one transaction at a time through an IDLE/ISSUE/WAIT state machine and returns read data to the owner. A watchdog aborts hung accesses.

## Interface
- `TIMEOUT`, 255: cycles in ISSUE+WAIT before abort (1..65535).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: request; held with payload stable until the matching gnt.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: store data, already lane-replicated.
- `m0_byteen`, `m1_byteen` in 4: lane enables; 4'b0000 means read.
- `m0_gnt`, `m1_gnt` out 1: one-cycle pulse, payload captured.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle pulse, read done or aborted.
- `m0_rdata`, `m1_rdata` out 32: read data, valid with rvalid, held until the next rvalid to that port.
- `err` out 1: one-cycle pulse on watchdog abort.
- `mem_req` out 1: transaction to memory.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_byteen` out 4: registered payload.
- `mem_ready` in 1: memory accepts when high together with mem_req.
- `mem_rvalid` in 1, `mem_rdata` in 32: read response.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req is high, pick a winner, latch its payload into the mem_* registers, set owner, and go to ISSUE. Otherwise stay.
- Winner selection is round-robin. With a single request, that requester wins. With both, the port not granted last wins. After reset the last-grant pointer is 1, so port 0 wins the first tie.
- ISSUE: mem_req=1. On mem_ready:
  - write: go to IDLE; no rvalid.
  - read: go to WAIT.
- WAIT: on mem_rvalid, latch mem_rdata into the owner's rdata, pulse the owner's rvalid next cycle, and go to IDLE.
- Watchdog counter is 16-bit. It clears on entry to ISSUE and increments each cycle in ISSUE or WAIT. When it reaches TIMEOUT:
  - go to IDLE and pulse err;
  - for a read, also pulse the owner's rvalid with rdata=0;
  - drop mem_req.
- mem_rvalid outside WAIT is ignored, including late responses after an abort.
- Requests are not sampled outside IDLE; the requester keeps holding req.
- Reset, including mid-transaction: state=IDLE, pointer=1, counter=0.
- Reset values: every output 0, including m0/m1_rdata and all mem_* outputs.

## Timing
- Request sampled at edge E (IDLE). gnt and mem_req go high in cycle E+1.
- Write with immediate mem_ready: done at end of E+1. The next arbitration samples at edge E+2, so the maximum throughput is 1 write per 2 cycles.
- Read with mem_ready in E+1 and mem_rvalid in E+2: owner rvalid in E+3, IDLE from E+3.
- mem_* payload stays stable from E+1 until acceptance.
- gnt is exactly 1 cycle. rvalid is exactly 1 cycle, and never on the non-owner port.
- Simultaneous mem_ready and watchdog expiry in ISSUE: acceptance wins.
- Simultaneous mem_rvalid and expiry in WAIT: data wins and err stays 0.

## Configuration
- `DM_ARB_CPU_PRIO_EN` defined: fixed priority; port 0 always wins a tie. The round-robin pointer is not implemented.
- Undefined: round-robin as described above.

## Test plan
- Port 0 write, addr 0x0000_1004, byteen 4'b1100, wdata 0xABCD_ABCD, mem_ready tied 1: m0_gnt at E+1; mem_addr=0x1004, mem_byteen=4'b1100 at E+1; no rvalid.
- Both ports read every cycle, memory answers 1 cycle after accept, no macro: grants alternate 0,1,0,1. m1_rdata equals the memory model's value for m1_addr, and m0_rvalid is never set for port 1's read.
- Same as the previous scenario with `DM_ARB_CPU_PRIO_EN` defined: port 1 never granted while port 0 requests continuously.
- TIMEOUT=8, port 1 read, mem_ready=1 but mem_rvalid never asserted:
  - at the 8th counted cycle: err=1, m1_rvalid=1, m1_rdata=0;
  - a mem_rvalid injected 2 cycles later is ignored.
- Reset asserted in WAIT during a port 0 read:
  - next cycle all outputs are 0 and the state is IDLE;
  - after release, a tie grants port 0 first.
- mem_ready held 0 for 5 cycles with TIMEOUT=255: mem_req and payload stay stable for all 5 cycles, and there is no err.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter/sequencer with watchdog abort.
// Define DM_ARB_CPU_PRIO_EN for fixed port-0 priority instead of round-robin.
module dm_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic r_owner, r_gnt0, r_gnt1, r_rv0, r_rv1, r_err;
  logic [15:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata0, r_rdata1;
  logic [3:0] r_byteen;
  logic w_win, w_grant, w_done, w_abort, w_ret, w_exp, w_rd;
`ifdef DM_ARB_CPU_PRIO_EN
  assign w_win = ~m0_req;
`else
  logic r_last;
  assign w_win = m1_req & (~m0_req | ~r_last);
  always_ff @(posedge clk)
    if (reset) r_last <= 1'b1;
    else if (w_grant) r_last <= w_win;
`endif
  // r_cnt holds the number of completed ISSUE/WAIT cycles, so expiry ends the TIMEOUT-th one
  assign w_exp = r_cnt >= LAST_CNT;
  assign w_rd = r_byteen == 4'b0000;
  assign w_ret = w_done | (w_abort & w_rd);
  always_comb begin
    w_next = r_state;
    w_grant = 1'b0;
    w_done = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant = m0_req | m1_req;
        w_next = w_grant ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        w_abort = ~mem_ready & w_exp;
        w_next = mem_ready ? (w_rd ? S_WAIT : S_IDLE) : (w_exp ? S_IDLE : S_ISSUE);
      end
      S_WAIT: begin
        w_done = mem_rvalid;
        w_abort = ~mem_rvalid & w_exp;
        w_next = (mem_rvalid | w_exp) ? S_IDLE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_cnt <= 16'd0;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
      r_err <= 1'b0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_byteen <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_grant ? 16'd0 : (r_state != S_IDLE && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
      r_gnt0 <= w_grant & ~w_win;
      r_gnt1 <= w_grant & w_win;
      r_rv0 <= w_ret & ~r_owner;
      r_rv1 <= w_ret & r_owner;
      r_err <= w_abort;
      if (w_ret & ~r_owner) r_rdata0 <= w_done ? mem_rdata : 32'd0;
      if (w_ret & r_owner) r_rdata1 <= w_done ? mem_rdata : 32'd0;
      if (w_grant) begin
        r_owner <= w_win;
        r_addr <= w_win ? m1_addr : m0_addr;
        r_wdata <= w_win ? m1_wdata : m0_wdata;
        r_byteen <= w_win ? m1_byteen : m0_byteen;
      end
    end
  end
  assign m0_gnt = r_gnt0;
  assign m1_gnt = r_gnt1;
  assign m0_rvalid = r_rv0;
  assign m1_rvalid = r_rv1;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
  assign err = r_err;
  assign mem_req = r_state == S_ISSUE;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_byteen = r_byteen;
endmodule
